mem_port_arbiter: RTL and testbench

- Shares the single program/data memory port between two requesters.
- Requester 0 is the instruction-fetch side (read-only). Requester 1 is the data side (read/write), used by memory-access opcodes.
- Sequences one memory transaction at a time through a small FSM and handles a configurable memory read latency.
- Returns read data and a one-cycle acknowledge to whichever requester was granted.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (read-only) and a data requester (read/write). One transaction
// is in flight at a time; it is sequenced IDLE -> ACCESS -> WAIT -> DONE.
// Memory read latency is RD_LATENCY cycles (1..15).
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// between the two ports. Without it, the data port has fixed priority.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   f_req, f_addr                    fetch request and address
//   f_ack, f_rdata                   fetch done pulse, fetch read data
//   d_req, d_we, d_addr, d_wdata     data request, write enable, addr, wdata
//   d_ack, d_rdata                   data done pulse, data read data
//   mem_addr, mem_we, mem_wdata      memory port request side
//   mem_rdata                        memory read data (RD_LATENCY after addr)
//   busy                             high while a transaction is in flight
//   grant_id                         owner of current/last transaction (1=data)
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lat_we;
    logic          pick_data;

    // Arbitration: which port wins if a grant happens this cycle.
`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;

    // On contention the port that was not granted last wins.
    assign pick_data = d_req && (!f_req || !rr_last);
`else
    assign pick_data = d_req;
`endif

    // Transaction sequencer; mem_addr/mem_wdata double as the operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last   <= 1'b0;
`endif
        end else begin
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_req || d_req) begin
                        grant_id <= pick_data;
                        mem_addr <= pick_data ? d_addr : f_addr;
                        if (pick_data) begin
                            mem_wdata <= d_wdata;
                        end
                        // Write strobe lands exactly in the ACCESS cycle.
                        mem_we   <= pick_data && d_we;
                        lat_we   <= pick_data && d_we;
                        busy     <= 1'b1;
                        state    <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_last  <= pick_data;
`endif
                    end
                end
                ACCESS: begin
                    cnt   <= CW'(RD_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // Final WAIT cycle is the one where mem_rdata is valid.
                        if (!lat_we) begin
                            if (grant_id) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                f_rdata <= mem_rdata;
                            end
                        end
                        if (grant_id) begin
                            d_ack <= 1'b1;
                        end else begin
                            f_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors, scoreboard of expected
// acknowledges (port, cycle, data) checked by independent monitors.
// dut0 runs with RD_LATENCY=1, dut1 with RD_LATENCY=4.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0 signals (RD_LATENCY = 1)
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        f_ack, d_ack, mem_we, busy, grant_id;
    logic [31:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    // dut1 signals (RD_LATENCY = 4)
    logic        f_req4 = 1'b0, d_req4 = 1'b0, d_we4 = 1'b0;
    logic [15:0] f_addr4 = '0, d_addr4 = '0;
    logic [31:0] d_wdata4 = '0;
    logic        f_ack4, d_ack4, mem_we4, busy4, grant_id4;
    logic [31:0] f_rdata4, d_rdata4, mem_wdata4, mem_rdata4;
    logic [15:0] mem_addr4;

    mem_port_arbiter #(.AW(16), .DW(32), .RD_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    mem_port_arbiter #(.AW(16), .DW(32), .RD_LATENCY(4)) dut1 (
        .clk(clk), .reset(reset),
        .f_req(f_req4), .f_addr(f_addr4), .f_ack(f_ack4), .f_rdata(f_rdata4),
        .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
        .d_ack(d_ack4), .d_rdata(d_rdata4),
        .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4), .grant_id(grant_id4)
    );

    // Memory model for dut0: one-cycle read pipeline, writes on mem_we.
    logic [31:0] mem0 [logic [15:0]];
    logic [31:0] rd0 = '0;
    assign mem_rdata = rd0;
    always @(posedge clk) begin
        rd0 <= mem0.exists(mem_addr) ? mem0[mem_addr] : 32'h0;
        if (mem_we) mem0[mem_addr] = mem_wdata;
    end

    // Memory model for dut1: valid word only in the final WAIT cycle.
    int good4 = -1;
    assign mem_rdata4 = (cyc == good4 && mem_addr4 == 16'h0070)
                        ? 32'hCAFE0004 : (32'hBAD00000 | 32'(cyc));

    int we_cnt = 0;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    typedef struct {
        logic        port;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitor for dut0.
    always @(negedge clk) begin
        exp_t e;
        if (f_ack || d_ack) begin
            chk("ack_exclusive", 64'(f_ack & d_ack), 64'd0);
            if (q0.size() == 0) begin
                fail_now("unexpected_ack");
            end else begin
                e = q0.pop_front();
                chk("ack_port", 64'(d_ack), 64'(e.port));
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ack_data", 64'(e.port ? d_rdata : f_rdata), 64'(e.data));
            end
        end
    end

    // Scoreboard monitor for dut1.
    always @(negedge clk) begin
        exp_t e;
        if (f_ack4 || d_ack4) begin
            if (q1.size() == 0) begin
                fail_now("unexpected_ack_lat4");
            end else begin
                e = q1.pop_front();
                chk("lat4_port", 64'(d_ack4), 64'(e.port));
                chk("lat4_cycle", 64'(cyc), 64'(e.cyc));
                chk("lat4_data", 64'(f_rdata4), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until any acknowledge is visible, bounded.
    task automatic wait_ack(input string name);
        for (int k = 0; k < 40; k++) begin
            step();
            if (f_ack || d_ack || f_ack4) return;
        end
        fail_now({name, "_timeout"});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int acks;
        logic [15:0] btb_addr [3];
        logic [31:0] btb_word [3];

        mem0[16'h0010] = 32'hF0000000;
        mem0[16'h0300] = 32'h33333333;
        mem0[16'h0040] = 32'h44444444;
        btb_addr[0] = 16'h0050; btb_word[0] = 32'h50505050;
        btb_addr[1] = 16'h0054; btb_word[1] = 32'h54545454;
        btb_addr[2] = 16'h0058; btb_word[2] = 32'h58585858;
        for (int i = 0; i < 3; i++) mem0[btb_addr[i]] = btb_word[i];

        // Reset state
        reset = 1'b1;
        d_req = 1'b1;
        step(); step(); step();
        chk("rst_ctrl0", 64'({f_ack, d_ack, busy, mem_we, grant_id}), 64'd0);
        chk("rst_data0", {f_rdata, d_rdata}, 64'd0);
        chk("rst_mem0", {mem_addr, mem_wdata}, 64'd0);
        chk("rst_ctrl1", 64'({f_ack4, d_ack4, busy4, mem_we4, grant_id4}), 64'd0);
        chk("rst_data1", {f_rdata4, d_rdata4}, 64'd0);
        chk("rst_mem1", {mem_addr4, mem_wdata4}, 64'd0);
        d_req = 1'b0;
        reset = 1'b0;
        step();

        // Single fetch read; operands changed mid-transaction must be ignored
        n = cyc;
        f_req = 1'b1; f_addr = 16'h0010;
        q0.push_back('{1'b0, n + 3, 32'hF0000000});
        step();
        chk("fetch_mem_addr", 64'(mem_addr), 64'h0010);
        chk("fetch_mem_we", 64'(mem_we), 64'd0);
        chk("fetch_busy", 64'({busy, grant_id}), 64'b10);
        f_addr = 16'h0099;
        wait_ack("fetch");
        f_req = 1'b0; f_addr = '0;
        step();

        // Data write: single-cycle write strobe, d_rdata unchanged
        n = cyc;
        we_cnt = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'hDEADBEEF;
        q0.push_back('{1'b1, n + 3, 32'h0});
        step();
        chk("write_strobe", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b1, 16'h0200, 32'hDEADBEEF});
        wait_ack("write");
        d_req = 1'b0; d_we = 1'b0;
        chk("write_we_cycles", 64'(we_cnt), 64'd1);
        step();

        // Data read of the word just written
        n = cyc;
        d_req = 1'b1; d_addr = 16'h0200;
        q0.push_back('{1'b1, n + 3, 32'hDEADBEEF});
        wait_ack("read");
        d_req = 1'b0;
        step();

        // Reset during WAIT of a data read
        d_req = 1'b1; d_addr = 16'h0010;
        step();
        step();
        reset = 1'b1; d_req = 1'b0;
        step();
        chk("midrst_busy", 64'({busy, d_ack, f_ack, mem_we}), 64'd0);
        chk("midrst_rdata", {d_rdata, f_rdata}, 64'd0);
        reset = 1'b0;
        step();
        n = cyc;
        f_req = 1'b1; f_addr = 16'h0010;
        q0.push_back('{1'b0, n + 3, 32'hF0000000});
        wait_ack("post_reset_fetch");
        f_req = 1'b0;
        step();

        // Contention: both requests from the same cycle
        n = cyc;
        f_req = 1'b1; f_addr = 16'h0040;
        d_req = 1'b1; d_addr = 16'h0300;
        acks = 0;
`ifdef ARB_ROUND_ROBIN_EN
        q0.push_back('{1'b1, n + 3,  32'h33333333});
        q0.push_back('{1'b0, n + 7,  32'h44444444});
        q0.push_back('{1'b1, n + 11, 32'h33333333});
        q0.push_back('{1'b0, n + 15, 32'h44444444});
        for (int k = 0; k < 60 && acks < 4; k++) begin
            step();
            if (f_ack || d_ack) acks++;
        end
        chk("contention_acks", 64'(acks), 64'd4);
        f_req = 1'b0; d_req = 1'b0;
`else
        q0.push_back('{1'b1, n + 3, 32'h33333333});
        q0.push_back('{1'b0, n + 7, 32'h44444444});
        for (int k = 0; k < 60 && acks < 2; k++) begin
            step();
            if (d_ack) begin d_req = 1'b0; acks++; end
            if (f_ack) begin f_req = 1'b0; acks++; end
        end
        chk("contention_acks", 64'(acks), 64'd2);
        f_req = 1'b0; d_req = 1'b0;
`endif
        step();

        // Back-to-back fetches with f_req held
        n = cyc;
        f_req = 1'b1; f_addr = btb_addr[0];
        for (int i = 0; i < 3; i++) q0.push_back('{1'b0, n + 3 + 4 * i, btb_word[i]});
        acks = 0;
        for (int k = 0; k < 60 && acks < 3; k++) begin
            step();
            if (f_ack) begin
                acks++;
                if (acks < 3) f_addr = btb_addr[acks];
                else f_req = 1'b0;
            end
        end
        chk("btb_acks", 64'(acks), 64'd3);
        f_req = 1'b0;
        step();

        // Latency 4: garbage on mem_rdata except the final WAIT cycle
        n = cyc;
        f_req4 = 1'b1; f_addr4 = 16'h0070;
        good4 = n + 5;
        q1.push_back('{1'b0, n + 6, 32'hCAFE0004});
        wait_ack("lat4");
        f_req4 = 1'b0;
        step(); step();

        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
